// File: rtl/serial_in_fifo.sv
// serial_in_fifo: 8N1 UART receiver feeding a small byte FIFO that the SFR
// block reads and pops through its serial-input register.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rxs
// START     | half-bit wait, then confirm the start bit (else glitch)
// DATA      | sampling 8 data bits, LSB first, one per bit time
// STOP      | waiting one bit time for the stop-bit sample
// WAIT_IDLE | bad stop bit / break, waiting for the line to return high
module serial_in_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     uart_rx,
  input  logic                     pop,
  input  logic                     clear_err,
  output logic [7:0]               rx_data,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     empty,
  output logic                     overrun,
  output logic                     frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  // Timer counts down to zero; the sample happens in the cycle it reads zero,
  // so it is loaded with one less than the wanted distance.
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            sync1;
  logic            rxs;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            stop_sample;
  logic            push;
  logic            stop_bad;
  logic            pop_ok;
  logic            full;
  logic            push_ok;
  logic            drop;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Receive FSM: start detection, bit timing and data shifting.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      tmr     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            tmr   <= T_HALF;
            state <= START;
          end
        end
        START: begin
          if (tmr == '0) begin
            if (!rxs) begin
              bit_idx <= '0;
              tmr     <= T_BIT;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DATA: begin
          if (tmr == '0) begin
            shreg <= {rxs, shreg[7:1]};
            tmr   <= T_BIT;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        STOP: begin
          if (tmr == '0) begin
            state <= rxs ? IDLE : WAIT_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit sample outcome; the push lands on the same edge as the sample.
  assign stop_sample = (state == STOP) && (tmr == '0);
  assign push        = stop_sample && rxs;
  assign stop_bad    = stop_sample && !rxs;

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign pop_ok  = pop && (count != '0);
  assign full    = (count == FULL_COUNT);
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)           overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
      if (stop_bad)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
    end
  end

  // Head byte is a function of registered pointer/storage only, so it
  // settles the cycle after any push or pop that moves the head.
  assign rx_count = count;
  assign empty    = (count == '0);
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_serial_in_fifo.sv
// Testbench for serial_in_fifo: frames are driven on the pin, the expected
// FIFO contents are kept in a queue, and a monitor pops and compares heads.
module tb_serial_in_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          uart_rx = 1'b1;
  logic          pop;
  logic          pop_stim = 1'b0;
  logic          pop_mon = 1'b0;
  logic          clear_err = 1'b0;
  logic [7:0]    rx_data;
  logic [CW-1:0] rx_count;
  logic          empty;
  logic          overrun;
  logic          frame_err;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [7:0]    exp_q[$];
  bit            exp_ovr = 1'b0;
  bit            exp_ferr = 1'b0;
  bit            drain_en = 1'b0;

  assign pop = pop_stim | pop_mon;

  serial_in_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .uart_rx   (uart_rx),
    .pop       (pop),
    .clear_err (clear_err),
    .rx_data   (rx_data),
    .rx_count  (rx_count),
    .empty     (empty),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at the current negedge; updates the model.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit = 1'b1);
    if (stop_bit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop_bit;
    wait_clks(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check({tag, ".count"},     32'(rx_count),  32'(exp_q.size()));
    check({tag, ".empty"},     32'(empty),     32'(exp_q.size() == 0));
    check({tag, ".rx_data"},   32'(rx_data),   32'(head));
    check({tag, ".overrun"},   32'(overrun),   32'(exp_ovr));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    wait_clks(1);
    clear_err = 1'b0;
    wait_clks(1);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    drain_en = 1'b1;
    while (!(exp_q.size() == 0 && empty) && budget < 4000) begin
      wait_clks(1);
      budget++;
    end
    wait_clks(3);
    drain_en = 1'b0;
    wait_clks(2);
    check({tag, ".drain_done"}, 32'(budget < 4000), 32'd1);
    check({tag, ".drained_empty"}, 32'(empty), 32'd1);
    check({tag, ".drained_data"}, 32'(rx_data), 32'h00);
    check({tag, ".drained_count"}, 32'(rx_count), 32'd0);
  endtask

  // Monitor: whenever draining and the DUT holds a byte, compare the head
  // against the model and pop it.
  initial begin
    forever begin
      @(negedge clk);
      if (drain_en && !empty && !pop_mon) begin
        if (exp_q.size() == 0) begin
          check("mon.unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
          pop_mon = 1'b1;
        end else begin
          check("mon.head", 32'(rx_data), 32'(exp_q.pop_front()));
          pop_mon = 1'b1;
        end
      end else begin
        pop_mon = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] head;

    // Reset state
    wait_clks(3);
    check_state("reset");
    nrst = 1'b1;
    wait_clks(5);

    // Single frame then pop
    send_frame(8'hA5);
    wait_clks(4);
    check_state("a5");
    drain("a5");

    // Short low glitch is rejected
    uart_rx = 1'b0;
    wait_clks(3);
    uart_rx = 1'b1;
    wait_clks(4 * CPB);
    check_state("glitch");

    // Overfill: 17 frames, the last is dropped
    for (int i = 0; i < 17; i++) send_frame(8'(i));
    wait_clks(4);
    check_state("overfill");
    drain("overfill");
    pulse_clear();
    check_state("overfill_clr");

    // Bad stop bit followed by a long break
    send_frame(8'h55, 1'b0);
    uart_rx = 1'b0;
    wait_clks(10 * CPB);
    check_state("break");
    pulse_clear();
    wait_clks(10 * CPB);
    uart_rx = 1'b1;
    wait_clks(3 * CPB);
    check_state("break_end");
    send_frame(8'h3C);
    wait_clks(4);
    check_state("after_break");
    drain("after_break");
    pulse_clear();
    check_state("after_break_clr");

    // Full FIFO with pop coinciding with the stop-sample push
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)));
    wait_clks(4);
    check_state("full");
    head = exp_q.pop_front();
    fork
      send_frame(8'hC3);
      begin
        wait_clks(78);
        pop_stim = 1'b1;
        check("simul.head_before", 32'(rx_data), 32'(head));
        wait_clks(1);
        pop_stim = 1'b0;
        check("simul.count", 32'(rx_count), 32'(DEPTH));
        check("simul.overrun", 32'(overrun), 32'd0);
      end
    join
    wait_clks(4);
    check_state("simul");
    drain("simul");

    // Reset in the middle of a frame
    fork
      send_frame(8'hFF);
      begin
        wait_clks(30);
        nrst = 1'b0;
        wait_clks(2);
        nrst = 1'b1;
      end
    join
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    wait_clks(2 * CPB);
    check_state("midreset");
    send_frame(8'h12);
    wait_clks(4);
    check_state("after_reset");
    drain("after_reset");

    // Random frames with random gaps while draining concurrently
    drain_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom_range(0, 255)));
      wait_clks($urandom_range(0, 2 * CPB));
    end
    drain("random");
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
